// File: rtl/oc8051_int_arb_pkg.sv
// Shared types and constants for the oc8051 interrupt arbiter: FSM encoding,
// default vector layout and the vector-address helper.
package oc8051_int_arb_pkg;

  typedef enum logic [0:0] {
    IARB_IDLE     = 1'b0,
    IARB_WAIT_ACK = 1'b1
  } iarb_state_e;

  localparam logic [7:0] IARB_VEC_BASE = 8'h03;
  localparam logic [7:0] IARB_VEC_STEP = 8'h08;

  // Low byte of the LCALL target; arithmetic wraps mod 256 on purpose.
  function automatic logic [7:0] iarb_vec(input logic [7:0] base,
                                          input logic [7:0] step,
                                          input logic [7:0] idx);
    return base + idx * step;
  endfunction

endpackage

// File: rtl/oc8051_int_arb_pri_enc.sv
// Priority encoder with start pointer: picks the lowest set index at or above
// ptr_i, wrapping to the lowest set index overall. ptr_i=0 gives fixed priority.
module oc8051_int_arb_pri_enc #(
  parameter int NSRC = 5,
  parameter int IW   = 3
) (
  input  logic [NSRC-1:0] mask_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [IW-1:0]   idx_o,
  output logic            valid_o
);

  logic [IW-1:0] up_idx;
  logic          up_v;
  logic [IW-1:0] any_idx;
  logic          any_v;

  // Descending scans so the lowest qualifying index is the last one written.
  always_comb begin
    up_idx  = '0;
    up_v    = 1'b0;
    any_idx = '0;
    any_v   = 1'b0;
    for (int k = NSRC - 1; k >= 0; k--) begin
      if (mask_i[k] && (k >= int'(ptr_i))) begin
        up_idx = IW'(k);
        up_v   = 1'b1;
      end
      if (mask_i[k]) begin
        any_idx = IW'(k);
        any_v   = 1'b1;
      end
    end
  end

  assign idx_o   = up_v ? up_idx : any_idx;
  assign valid_o = any_v;

endmodule

// File: rtl/oc8051_int_arb.sv
// Interrupt arbiter for the oc8051 op-select stage: two-level nested priority,
// one-cycle intr pulse with vector, ack handshake, RETI unwinding.
// Define OC8051_INT_RR_EN for round-robin within a level (default: fixed priority).
//
// Handshake: intr is a one-cycle request carrying int_v; the FSM then holds in
// WAIT_ACK until ack pulses, which commits the service level and pulses clr.
module oc8051_int_arb
  import oc8051_int_arb_pkg::*;
#(
  parameter int         NSRC     = 5,
  parameter logic [7:0] VEC_BASE = IARB_VEC_BASE,
  parameter logic [7:0] VEC_STEP = IARB_VEC_STEP
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NSRC-1:0] req,
  input  logic            ea,
  input  logic [NSRC-1:0] ie,
  input  logic [NSRC-1:0] ip,
  input  logic            blk,
  input  logic            ack,
  input  logic            reti,
  output logic            intr,
  output logic [7:0]      int_v,
  output logic [NSRC-1:0] clr,
  output logic            in_lo,
  output logic            in_hi,
  output iarb_state_e     state_dbg
);

  localparam int IW = (NSRC > 1) ? $clog2(NSRC) : 1;

  iarb_state_e     state_q, state_d;
  logic [IW-1:0]   sel_idx_q, sel_idx_d;
  logic            sel_ip_q, sel_ip_d;
  logic            intr_q, intr_d;
  logic [7:0]      int_v_q, int_v_d;
  logic [NSRC-1:0] clr_q, clr_d;
  logic            in_lo_q, in_lo_d;
  logic            in_hi_q, in_hi_d;

  logic [NSRC-1:0] elig, hi_c, lo_c, allowed;
  logic [IW-1:0]   enc_idx, ptr;
  logic            enc_v;

  assign elig = req & ie & {NSRC{ea}};
  assign hi_c = elig & ip;
  assign lo_c = elig & ~ip;

  // High service masks everything; low service admits only high requests.
  always_comb begin
    allowed = '0;
    if (in_hi_q)      allowed = '0;
    else if (in_lo_q) allowed = hi_c;
    else if (|hi_c)   allowed = hi_c;
    else              allowed = lo_c;
  end

  oc8051_int_arb_pri_enc #(
    .NSRC (NSRC),
    .IW   (IW)
  ) u_pri_enc (
    .mask_i  (allowed),
    .ptr_i   (ptr),
    .idx_o   (enc_idx),
    .valid_o (enc_v)
  );

`ifdef OC8051_INT_RR_EN
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (state_q == IARB_WAIT_ACK && ack) begin
      rr_ptr_d = (sel_idx_q == IW'(NSRC - 1)) ? '0 : sel_idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rr_ptr_q <= '0;
    else     rr_ptr_q <= rr_ptr_d;
  end

  assign ptr = rr_ptr_q;
`else
  assign ptr = '0;
`endif

  always_comb begin
    state_d   = state_q;
    sel_idx_d = sel_idx_q;
    sel_ip_d  = sel_ip_q;
    intr_d    = 1'b0;
    int_v_d   = int_v_q;
    clr_d     = '0;
    in_lo_d   = in_lo_q;
    in_hi_d   = in_hi_q;

    // RETI unwinds first so a same-cycle ack lands on the popped level.
    if (reti) begin
      if (in_hi_q)      in_hi_d = 1'b0;
      else if (in_lo_q) in_lo_d = 1'b0;
    end

    case (state_q)
      IARB_IDLE: begin
        if (!blk && enc_v) begin
          intr_d    = 1'b1;
          int_v_d   = iarb_vec(VEC_BASE, VEC_STEP, 8'(enc_idx));
          sel_idx_d = enc_idx;
          sel_ip_d  = ip[enc_idx];
          state_d   = IARB_WAIT_ACK;
        end
      end
      IARB_WAIT_ACK: begin
        if (ack) begin
          clr_d = NSRC'(1) << sel_idx_q;
          if (sel_ip_q) in_hi_d = 1'b1;
          else          in_lo_d = 1'b1;
          state_d = IARB_IDLE;
        end
      end
      default: state_d = IARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IARB_IDLE;
      sel_idx_q <= '0;
      sel_ip_q  <= 1'b0;
      intr_q    <= 1'b0;
      int_v_q   <= 8'h00;
      clr_q     <= '0;
      in_lo_q   <= 1'b0;
      in_hi_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_idx_q <= sel_idx_d;
      sel_ip_q  <= sel_ip_d;
      intr_q    <= intr_d;
      int_v_q   <= int_v_d;
      clr_q     <= clr_d;
      in_lo_q   <= in_lo_d;
      in_hi_q   <= in_hi_d;
    end
  end

  assign intr      = intr_q;
  assign int_v     = int_v_q;
  assign clr       = clr_q;
  assign in_lo     = in_lo_q;
  assign in_hi     = in_hi_q;
  assign state_dbg = state_q;

endmodule
